multicycle_control_fsm: RTL

//  Multi-cycle main controller for the RV32I subset datapath (addi/slti/ori/andi/slli, add/sub/slt/or/and/sll,
//  lw, sw, beq, bne, jal, jalr, lui). Sequences a shared ALU + unified memory over FETCH..WRITEBACK states,

---
 rtl/multicycle_control_fsm_pkg.sv | 83 ++++++++
 rtl/multicycle_control_fsm_if.sv | 14 +
 rtl/multicycle_control_fsm_alu_decoder.sv | 37 +++
 rtl/multicycle_control_fsm.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I-subset controller.
// Contents: controller state enum, opcode constants, the encodings of every
// datapath select driven by the controller, and two small decode helpers.
package multicycle_control_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_JALRLNK,
    S_LUI
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_SLL   = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_PASSB = 3'b110;

  // Coarse ALU request from the FSM; FUNCT defers to the funct3/funct7 decode.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_PASSB = 2'b11;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Immediate format implied by the opcode; I-format covers lw, jalr and ALU-immediate.
  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      OP_LUI:    return IMM_U;
      default:   return IMM_I;
    endcase
  endfunction

  // funct3 values implemented for register and immediate ALU instructions.
  function automatic logic alu_funct3_ok(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001, 3'b010, 3'b110, 3'b111: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Unified-memory handshake between the controller and the memory.
//   mem_req   : controller -> memory, access request held until mem_ready
//   AdrSrc    : controller -> memory address mux, 0=PC, 1=ALUOut
//   MemWrite  : controller -> memory, store strobe (only with mem_req)
//   mem_ready : memory -> controller, access completes this cycle
interface multicycle_control_fsm_if;
  logic mem_req;
  logic AdrSrc;
  logic MemWrite;
  logic mem_ready;

  modport master (output mem_req, output AdrSrc, output MemWrite, input mem_ready);
  modport slave  (input mem_req, input AdrSrc, input MemWrite, output mem_ready);
endinterface

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// Combinational ALU control decode.
//   op       in  7  opcode
//   funct3   in  3  instruction funct3
//   funct7_5 in  1  instruction bit 30 (sub select, R-type only)
//   alu_op   in  2  coarse request from the FSM
//   alu_ctrl out 3  ALU operation
module multicycle_control_fsm_alu_decoder
  import multicycle_control_fsm_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic [1:0] alu_op,
  output logic [2:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op)
      ALUOP_SUB:   alu_ctrl = ALU_SUB;
      ALUOP_PASSB: alu_ctrl = ALU_PASSB;
      ALUOP_FUNCT: begin
        case (funct3)
          // bit 30 of an I-type is immediate data, so only R-type may select sub
          3'b000:  alu_ctrl = (op == OP_RTYPE && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b110:  alu_ctrl = ALU_OR;
          3'b111:  alu_ctrl = ALU_AND;
          3'b001:  alu_ctrl = ALU_SLL;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default:     alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle main controller for an RV32I-subset datapath sharing one ALU
// and one unified memory. Sequences FETCH..WRITEBACK, drives datapath
// selects/enables and handshakes with memory.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   instr      instruction register (stable from DECODE to end of instruction)
//   EQ         ALU equal flag, current cycle
//   mem        memory handshake (mem_req, AdrSrc, MemWrite out; mem_ready in)
//   IRWrite, PCWrite, RegWrite       enables
//   ResultSrc, ALUSrcA, ALUSrcB      datapath selects
//   ALUctrl, ImmSrc                  ALU operation, immediate format
//   retire     pulse in last cycle of each instruction
//   illegal    pulse in DECODE for an unsupported instruction
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic [31:0]                     instr,
  input  logic                            EQ,
  multicycle_control_fsm_if.master        mem,
  output logic                            IRWrite,
  output logic                            PCWrite,
  output logic                            RegWrite,
  output logic [1:0]                      ResultSrc,
  output logic [1:0]                      ALUSrcA,
  output logic [1:0]                      ALUSrcB,
  output logic [2:0]                      ALUctrl,
  output logic [2:0]                      ImmSrc,
  output logic                            retire,
  output logic                            illegal
);

  state_t     state_q, state_d;

  logic [6:0] op;
  logic [2:0] funct3;
  logic       mem_req_c, adr_src_c, mem_write_c;
  logic       ir_write_c, pc_write_c, reg_write_c;
  logic [1:0] result_src_c, src_a_c, src_b_c, alu_op_c;
  logic       retire_c, illegal_c;
  logic [2:0] alu_ctrl_dec;

  // Register numbers and immediate bits belong to the datapath, not the controller.
  logic       unused_instr_bits;
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  assign op     = instr[6:0];
  assign funct3 = instr[14:12];

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    mem_req_c    = 1'b0;
    adr_src_c    = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    result_src_c = RES_ALUOUT;
    src_a_c      = SRCA_PC;
    src_b_c      = SRCB_RS2;
    alu_op_c     = ALUOP_ADD;
    retire_c     = 1'b0;
    illegal_c    = 1'b0;
    case (state_q)
      S_FETCH: begin
        // PC+4 goes straight from the ALU into PC while the instruction loads
        mem_req_c    = 1'b1;
        src_b_c      = SRCB_FOUR;
        result_src_c = RES_ALURESULT;
        if (mem.mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        // OldPC+imm lands in ALUOut: branch/jal target computed speculatively
        src_a_c = SRCA_OLDPC;
        src_b_c = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:  if (alu_funct3_ok(funct3)) state_d = S_EXECR; else illegal_c = 1'b1;
          OP_ITYPE:  if (alu_funct3_ok(funct3)) state_d = S_EXECI; else illegal_c = 1'b1;
          OP_BRANCH: if (funct3[2:1] == 2'b00)  state_d = S_BRANCH; else illegal_c = 1'b1;
          OP_JAL:    state_d = S_JAL;
          OP_JALR:   state_d = S_JALR;
          OP_LUI:    state_d = S_LUI;
          default:   illegal_c = 1'b1;
        endcase
        // PC was already advanced in FETCH, so an illegal word is simply skipped
        if (illegal_c) state_d = S_FETCH;
      end
      S_MEMADR: begin
        src_a_c = SRCA_RS1;
        src_b_c = SRCB_IMM;
        state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req_c = 1'b1;
        adr_src_c = 1'b1;
        if (mem.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src_c = RES_READDATA;
        reg_write_c  = 1'b1;
        retire_c     = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        adr_src_c   = 1'b1;
        if (mem.mem_ready) begin
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_EXECR: begin
        src_a_c  = SRCA_RS1;
        src_b_c  = SRCB_RS2;
        alu_op_c = ALUOP_FUNCT;
        state_d  = S_ALUWB;
      end
      S_EXECI: begin
        src_a_c  = SRCA_RS1;
        src_b_c  = SRCB_IMM;
        alu_op_c = ALUOP_FUNCT;
        state_d  = S_ALUWB;
      end
      S_ALUWB: begin
        result_src_c = RES_ALUOUT;
        reg_write_c  = 1'b1;
        retire_c     = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        // target sits in ALUOut from DECODE; funct3[0] distinguishes bne from beq
        src_a_c      = SRCA_RS1;
        src_b_c      = SRCB_RS2;
        alu_op_c     = ALUOP_SUB;
        result_src_c = RES_ALUOUT;
        pc_write_c   = funct3[0] ? !EQ : EQ;
        retire_c     = 1'b1;
        state_d      = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target from ALUOut while the ALU forms the link OldPC+4
        src_a_c      = SRCA_OLDPC;
        src_b_c      = SRCB_FOUR;
        result_src_c = RES_ALUOUT;
        pc_write_c   = 1'b1;
        state_d      = S_ALUWB;
      end
      S_JALR: begin
        // rs1 consumed before the link write, so rd == rs1 is safe
        src_a_c      = SRCA_RS1;
        src_b_c      = SRCB_IMM;
        result_src_c = RES_ALURESULT;
        pc_write_c   = 1'b1;
        state_d      = S_JALRLNK;
      end
      S_JALRLNK: begin
        src_a_c      = SRCA_OLDPC;
        src_b_c      = SRCB_FOUR;
        result_src_c = RES_ALURESULT;
        reg_write_c  = 1'b1;
        retire_c     = 1'b1;
        state_d      = S_FETCH;
      end
      S_LUI: begin
        src_b_c  = SRCB_IMM;
        alu_op_c = ALUOP_PASSB;
        state_d  = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  multicycle_control_fsm_alu_decoder u_alu_decoder (
    .op       (op),
    .funct3   (funct3),
    .funct7_5 (instr[30]),
    .alu_op   (alu_op_c),
    .alu_ctrl (alu_ctrl_dec)
  );

  // Reset forces every output low in the cycle it is asserted, aborting any access.
  assign mem.mem_req  = rst ? 1'b0 : mem_req_c;
  assign mem.AdrSrc   = rst ? 1'b0 : adr_src_c;
  assign mem.MemWrite = rst ? 1'b0 : mem_write_c;
  assign IRWrite      = rst ? 1'b0 : ir_write_c;
  assign PCWrite      = rst ? 1'b0 : pc_write_c;
  assign RegWrite     = rst ? 1'b0 : reg_write_c;
  assign ResultSrc    = rst ? 2'b00 : result_src_c;
  assign ALUSrcA      = rst ? 2'b00 : src_a_c;
  assign ALUSrcB      = rst ? 2'b00 : src_b_c;
  assign ALUctrl      = rst ? 3'b000 : alu_ctrl_dec;
  assign ImmSrc       = rst ? 3'b000 : imm_src_of(op);
  assign retire       = rst ? 1'b0 : retire_c;
  assign illegal      = rst ? 1'b0 : illegal_c;

endmodule
